mem_stage: RTL and testbench

- Memory-access stage between execute and decode's writeback inputs.
- Takes the registered execute-stage result and memory controls, and performs one word access on a data-memory request/grant/response interface.
- Drives the wb_* bus (wb_res, wb_memdata, wb_rwe, wb_fwe, wb_mre, wb_rd) that the decode stage consumes.
- Generates the pipeline advance signal n_stall, low while an access is outstanding.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mem_stage.sv | 109 ++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: data-path widths and memory-stage FSM states.
package cpu_pkg;

  localparam int AW = 25;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    HOLD
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data-memory word access per op and
// registers the writeback bus consumed by decode.
module mem_stage #(
  parameter int AW = cpu_pkg::AW,
  parameter int DW = cpu_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ex_res,
  input  logic [DW-1:0] ex_sdata,
  input  logic [AW-1:0] ex_daddr,
  input  logic [4:0]    ex_rd,
  input  logic          ex_rwe,
  input  logic          ex_fwe,
  input  logic          ex_mre,
  input  logic          ex_mwe,
  input  logic          n_stall_in,
  output logic          n_stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] wb_res,
  output logic [DW-1:0] wb_memdata,
  output logic          wb_rwe,
  output logic          wb_fwe,
  output logic          wb_mre,
  output logic [4:0]    wb_rd
);
  import cpu_pkg::*;

  mem_state_t    state, state_nxt;
  logic          memop;
  logic          ready;
  logic          rsp_take;
  logic [DW-1:0] load_buf;

  assign memop      = ex_mre | ex_mwe;
  assign dmem_addr  = ex_daddr;
  assign dmem_wdata = ex_sdata;
  assign dmem_we    = ex_mwe;
  assign n_stall    = n_stall_in & ready;

  // rvalid only counts while a load is outstanding; stray responses are dropped
  assign rsp_take = (state == WAIT_RESP) && dmem_rvalid;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    dmem_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!memop) begin
          ready = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (ex_mwe) begin
              // store is done once granted; HOLD keeps it from re-issuing
              ready = 1'b1;
              if (!n_stall_in) state_nxt = HOLD;
            end else begin
              state_nxt = WAIT_RESP;
            end
          end
        end
      end
      WAIT_RESP: begin
        if (dmem_rvalid) begin
          ready     = 1'b1;
          state_nxt = n_stall_in ? IDLE : HOLD;
        end
      end
      HOLD: begin
        ready = 1'b1;
        if (n_stall_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_buf   <= '0;
      wb_res     <= '0;
      wb_memdata <= '0;
      wb_rwe     <= 1'b0;
      wb_fwe     <= 1'b0;
      wb_mre     <= 1'b0;
      wb_rd      <= '0;
    end else begin
      state <= state_nxt;
      if (rsp_take) load_buf <= dmem_rdata;
      if (n_stall) begin
        wb_res     <= ex_res;
        wb_rd      <= ex_rd;
        wb_rwe     <= ex_rwe & ~ex_mwe;
        wb_fwe     <= ex_fwe & ~ex_mwe;
        wb_mre     <= ex_mre & ~ex_mwe;
        wb_memdata <= rsp_take ? dmem_rdata : load_buf;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes the expected writeback word for
// every advancing cycle, a monitor pops and compares after each update edge.
module tb_mem_stage;
  localparam int AW = 25;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ex_res, ex_sdata;
  logic [AW-1:0] ex_daddr;
  logic [4:0]    ex_rd;
  logic          ex_rwe, ex_fwe, ex_mre, ex_mwe;
  logic          n_stall_in;
  logic          n_stall;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_gnt, dmem_rvalid;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] wb_res, wb_memdata;
  logic          wb_rwe, wb_fwe, wb_mre;
  logic [4:0]    wb_rd;

  mem_stage #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ex_res(ex_res), .ex_sdata(ex_sdata), .ex_daddr(ex_daddr), .ex_rd(ex_rd),
    .ex_rwe(ex_rwe), .ex_fwe(ex_fwe), .ex_mre(ex_mre), .ex_mwe(ex_mwe),
    .n_stall_in(n_stall_in), .n_stall(n_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .wb_res(wb_res), .wb_memdata(wb_memdata), .wb_rwe(wb_rwe), .wb_fwe(wb_fwe),
    .wb_mre(wb_mre), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] memdata;
    logic        rwe;
    logic        fwe;
    logic        mre;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned req_cycles, acc;
  logic [31:0] mdl_buf;
  bit          fire = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_op(input logic [31:0] res, input logic [31:0] sdata,
                        input logic [24:0] daddr, input logic [4:0] rd,
                        input logic rwe, input logic fwe, input logic mre,
                        input logic mwe, input logic [31:0] mexp);
    ex_res = res; ex_sdata = sdata; ex_daddr = daddr; ex_rd = rd;
    ex_rwe = rwe; ex_fwe = fwe; ex_mre = mre; ex_mwe = mwe;
    cur_exp.res     = res;
    cur_exp.memdata = mexp;
    cur_exp.rwe     = rwe & ~mwe;
    cur_exp.fwe     = fwe & ~mwe;
    cur_exp.mre     = mre & ~mwe;
    cur_exp.rd      = rd;
  endtask

  task automatic nop();
    set_op(32'hAA, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mdl_buf);
  endtask

  // Entered at posedge+1; drives the memory side for one cycle, checks the
  // combinational outputs, and queues the expected writeback when it advances.
  task automatic run_cycle(input bit gnt, input bit rv, input logic [31:0] rdata,
                           input bit exp_adv, input bit exp_req, input string name);
    dmem_gnt = gnt; dmem_rvalid = rv; dmem_rdata = rdata;
    #1;
    chk({name, "_nstall"}, {79'd0, n_stall}, {79'd0, exp_adv});
    chk({name, "_req"}, {79'd0, dmem_req}, {79'd0, exp_req});
    if (dmem_req) req_cycles++;
    if (dmem_req && gnt) acc++;
    if (n_stall && !rst) sb.push_back(cur_exp);
    @(posedge clk); #1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  always @(negedge clk) fire = n_stall && !rst;

  always @(posedge clk) begin
    if (fire) begin
      exp_t e;
      #1;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: got writeback update expected none");
      end else begin
        e = sb.pop_front();
        chk("wb", {8'd0, wb_res, wb_memdata, wb_rwe, wb_fwe, wb_mre, wb_rd}, {8'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; n_stall_in = 1'b1; mdl_buf = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    req_cycles = 0; acc = 0;
    nop();
    @(posedge clk); #1;
    run_cycle(0, 0, '0, 1, 0, "rst0");
    run_cycle(0, 0, '0, 1, 0, "rst1");
    chk("rst_wb", {8'd0, wb_res, wb_memdata, wb_rwe, wb_fwe, wb_mre, wb_rd}, '0);
    rst = 1'b0;

    // ALU op
    req_cycles = 0;
    set_op(32'h12345678, '0, '0, 5'd5, 1, 0, 0, 0, mdl_buf);
    run_cycle(0, 0, '0, 1, 0, "alu");
    nop();
    run_cycle(0, 0, '0, 1, 0, "alu_nop");
    chk("alu_no_req", {48'd0, req_cycles}, 80'd0);

    // Store granted on third request cycle
    req_cycles = 0; acc = 0;
    set_op(32'h40, 32'hDEADBEEF, 25'h40, 5'd3, 1, 0, 0, 1, mdl_buf);
    #1;
    chk("st_addr", {55'd0, dmem_addr}, 80'h40);
    chk("st_wdata", {48'd0, dmem_wdata}, 80'hDEADBEEF);
    chk("st_we", {79'd0, dmem_we}, 80'd1);
    run_cycle(0, 0, '0, 0, 1, "st_w0");
    run_cycle(0, 0, '0, 0, 1, "st_w1");
    run_cycle(1, 0, '0, 1, 1, "st_gnt");
    chk("st_req_cycles", {48'd0, req_cycles}, 80'd3);
    chk("st_accepts", {48'd0, acc}, 80'd1);
    nop();
    run_cycle(0, 0, '0, 1, 0, "st_after");

    // Load, rvalid three cycles after gnt
    set_op(32'h80, '0, 25'h80, 5'd7, 1, 0, 1, 0, 32'hCAFEF00D);
    run_cycle(1, 0, '0, 0, 1, "ld_c0");
    run_cycle(0, 0, '0, 0, 0, "ld_c1");
    run_cycle(0, 0, '0, 0, 0, "ld_c2");
    run_cycle(0, 1, 32'hCAFEF00D, 1, 0, "ld_c3");
    mdl_buf = 32'hCAFEF00D;
    nop();
    run_cycle(0, 0, '0, 1, 0, "ld_after");

    // Load completes while downstream stalls; data must come from the buffer
    acc = 0;
    set_op(32'h90, '0, 25'h90, 5'd9, 1, 0, 1, 0, 32'h0BADF00D);
    n_stall_in = 1'b0;
    run_cycle(1, 0, '0, 0, 1, "hl_gnt");
    run_cycle(0, 1, 32'h0BADF00D, 0, 0, "hl_rv");
    for (int i = 0; i < 4; i++) run_cycle(0, 0, 32'hFFFFFFFF, 0, 0, "hl_hold");
    n_stall_in = 1'b1;
    run_cycle(0, 0, 32'hFFFFFFFF, 1, 0, "hl_rel");
    chk("hl_accepts", {48'd0, acc}, 80'd1);
    mdl_buf = 32'h0BADF00D;
    nop();
    run_cycle(0, 0, '0, 1, 0, "hl_after");

    // Store granted while stalled: no re-issue from HOLD
    acc = 0;
    set_op(32'h44, 32'h01020304, 25'h44, 5'd6, 1, 0, 0, 1, mdl_buf);
    n_stall_in = 1'b0;
    run_cycle(1, 0, '0, 0, 1, "sh_gnt");
    run_cycle(0, 0, '0, 0, 0, "sh_hold");
    n_stall_in = 1'b1;
    run_cycle(0, 0, '0, 1, 0, "sh_rel");
    chk("sh_accepts", {48'd0, acc}, 80'd1);
    nop();
    run_cycle(0, 0, '0, 1, 0, "sh_after");

    // Reset while waiting for a load response
    set_op(32'h88, '0, 25'h88, 5'd4, 1, 0, 1, 0, 32'h77777777);
    run_cycle(1, 0, '0, 0, 1, "rs_gnt");
    rst = 1'b1;
    mdl_buf = '0;
    nop();
    run_cycle(0, 0, '0, 0, 0, "rs_cyc");
    chk("rs_wb", {8'd0, wb_res, wb_memdata, wb_rwe, wb_fwe, wb_mre, wb_rd}, '0);
    rst = 1'b0;
    run_cycle(0, 1, 32'h55555555, 1, 0, "rs_late_rv");
    n_stall_in = 1'b0;
    run_cycle(0, 0, '0, 0, 0, "rs_nsi0");
    n_stall_in = 1'b1;
    run_cycle(0, 0, '0, 1, 0, "rs_nsi1");

    // Load and store both set: treated as a store
    set_op(32'h100, 32'h11112222, 25'h100, 5'd2, 1, 0, 1, 1, mdl_buf);
    #1;
    chk("both_we", {79'd0, dmem_we}, 80'd1);
    run_cycle(1, 0, '0, 1, 1, "both_gnt");
    nop();
    run_cycle(0, 0, '0, 1, 0, "both_after");

    // Back-to-back minimum-latency loads
    set_op(32'h200, '0, 25'h200, 5'd10, 1, 0, 1, 0, 32'hA0A0A0A0);
    run_cycle(1, 0, '0, 0, 1, "b2b_a_gnt");
    run_cycle(0, 1, 32'hA0A0A0A0, 1, 0, "b2b_a_rv");
    mdl_buf = 32'hA0A0A0A0;
    set_op(32'h204, '0, 25'h204, 5'd11, 0, 1, 1, 0, 32'hB0B0B0B0);
    run_cycle(1, 0, '0, 0, 1, "b2b_b_gnt");
    run_cycle(0, 1, 32'hB0B0B0B0, 1, 0, "b2b_b_rv");
    mdl_buf = 32'hB0B0B0B0;
    nop();
    run_cycle(0, 0, '0, 1, 0, "b2b_after");
    run_cycle(0, 0, '0, 1, 0, "drain");

    chk("sb_drain", {48'd0, sb.size()}, 80'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
